// File: rtl/jtag_reg_scan_ctrl.sv
// jtag_reg_scan_ctrl
// Walks the host-written JTAG register image one byte per enabled cycle,
// compares each byte with a shadow copy, and hands every changed byte to
// the consumer as an (address, data) update over a valid/ready handshake.
// A force request makes one full lap emit every byte regardless of change.
module jtag_reg_scan_ctrl #(
    parameter int C_N_BYTE = 128,
    parameter int C_AW     = $clog2(C_N_BYTE)
) (
    input  logic                  CK_i,
    input  logic                  XARST_i,
    input  logic                  CK_EE_i,
    input  logic [8*C_N_BYTE-1:0] REGss_i,
    input  logic                  FORCE_i,
    input  logic                  UPD_RDY_i,
    output logic                  UPD_VLD_o,
    output logic [C_AW-1:0]       UPD_ADR_o,
    output logic [7:0]            UPD_DAT_o,
    output logic                  FORCE_BSY_o,
    output logic                  WRAP_o
);

    typedef enum logic {
        S_SCAN = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [C_AW-1:0] LAST_PTR = C_AW'(C_N_BYTE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [C_AW-1:0] ptr;
    logic [C_AW-1:0] ptr_nxt;
    logic [C_AW-1:0] ptr_inc;
    logic [C_AW-1:0] force_end;
    logic [C_AW-1:0] force_end_nxt;
    logic [C_AW-1:0] adr_nxt;
    logic [7:0]      dat_nxt;
    logic [7:0]      cur_byte;
    logic            vld_nxt;
    logic            bsy_nxt;
    logic            wrap_nxt;
    logic            advance;
    logic            shadow_we;
    logic [7:0]      shadow [C_N_BYTE];

    // Explicit wrap compare so non-power-of-2 image sizes work
    assign ptr_inc  = (ptr == LAST_PTR) ? '0 : ptr + C_AW'(1);
    assign cur_byte = REGss_i[{ptr, 3'b000} +: 8];

    // Next-state and next-output decode; everything holds while the enable is low
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        force_end_nxt = force_end;
        bsy_nxt       = FORCE_BSY_o;
        vld_nxt       = UPD_VLD_o;
        adr_nxt       = UPD_ADR_o;
        dat_nxt       = UPD_DAT_o;
        wrap_nxt      = WRAP_o;
        advance       = 1'b0;
        shadow_we     = 1'b0;
        if (CK_EE_i) begin
            wrap_nxt = 1'b0;
            case (state)
                S_SCAN: begin
                    // A force request in this very cycle already makes the current byte count
                    if ((cur_byte != shadow[ptr]) || FORCE_BSY_o || FORCE_i) begin
                        vld_nxt   = 1'b1;
                        adr_nxt   = ptr;
                        dat_nxt   = cur_byte;
                        state_nxt = S_HOLD;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (UPD_RDY_i) begin
                        shadow_we = 1'b1;
                        vld_nxt   = 1'b0;
                        advance   = 1'b1;
                        state_nxt = S_SCAN;
                    end
                end
                default: begin
                    state_nxt = S_SCAN;
                end
            endcase
            if (advance) begin
                ptr_nxt  = ptr_inc;
                wrap_nxt = (ptr == LAST_PTR);
                if (FORCE_BSY_o && (ptr_inc == force_end)) begin
                    bsy_nxt = 1'b0;
                end
            end
            // A new force request (re)starts the lap from the current pointer
            if (FORCE_i) begin
                force_end_nxt = ptr;
                bsy_nxt       = 1'b1;
            end
        end
    end

    // State, pointer and output registers
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state       <= S_SCAN;
            ptr         <= '0;
            force_end   <= '0;
            FORCE_BSY_o <= 1'b0;
            UPD_VLD_o   <= 1'b0;
            UPD_ADR_o   <= '0;
            UPD_DAT_o   <= '0;
            WRAP_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            force_end   <= force_end_nxt;
            FORCE_BSY_o <= bsy_nxt;
            UPD_VLD_o   <= vld_nxt;
            UPD_ADR_o   <= adr_nxt;
            UPD_DAT_o   <= dat_nxt;
            WRAP_o      <= wrap_nxt;
        end
    end

    // Shadow copy records the value actually handed over, not the live byte
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int i = 0; i < C_N_BYTE; i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (shadow_we) begin
            shadow[ptr] <= UPD_DAT_o;
        end
    end

endmodule

// File: tb/tb_jtag_reg_scan_ctrl.sv
// tb_jtag_reg_scan_ctrl
// Directed scenarios plus a randomized phase, checked every cycle against a
// transaction-level reference model (pending update, lap counter for force).
module tb_jtag_reg_scan_ctrl;

    localparam int N  = 128;
    localparam int AW = 7;

    logic          CK = 1'b0;
    logic          XARST = 1'b0;
    logic          CK_EE = 1'b0;
    logic          FORCE = 1'b0;
    logic          RDY = 1'b0;
    logic [8*N-1:0] REGss;
    logic          vld;
    logic [AW-1:0] adr;
    logic [7:0]    dat;
    logic          bsy;
    logic          wrap;

    logic [7:0]    img [N];

    int checks = 0;
    int failures = 0;

    int            m_ptr;
    logic [7:0]    m_shadow [N];
    bit            m_pending;
    int            m_adr;
    logic [7:0]    m_dat;
    int            m_force_left;
    bit            m_wrap;

    jtag_reg_scan_ctrl #(.C_N_BYTE(N), .C_AW(AW)) dut (
        .CK_i       (CK),
        .XARST_i    (XARST),
        .CK_EE_i    (CK_EE),
        .REGss_i    (REGss),
        .FORCE_i    (FORCE),
        .UPD_RDY_i  (RDY),
        .UPD_VLD_o  (vld),
        .UPD_ADR_o  (adr),
        .UPD_DAT_o  (dat),
        .FORCE_BSY_o(bsy),
        .WRAP_o     (wrap)
    );

    always #5 CK = ~CK;

    always_comb begin
        REGss = '0;
        for (int k = 0; k < N; k++) begin
            REGss[8*k +: 8] = img[k];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("vld",  32'(vld),  32'(m_pending));
        checkOutput("adr",  32'(adr),  32'(m_adr));
        checkOutput("dat",  32'(dat),  32'(m_dat));
        checkOutput("bsy",  32'(bsy),  32'(m_force_left > 0));
        checkOutput("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic modelReset();
        m_ptr = 0;
        for (int k = 0; k < N; k++) m_shadow[k] = 8'h00;
        m_pending = 1'b0;
        m_adr = 0;
        m_dat = 8'h00;
        m_force_left = 0;
        m_wrap = 1'b0;
    endtask

    // One enabled cycle: either finish the pending transfer or look at the next byte;
    // a force lap is simply "the next N accepted updates"
    task automatic modelStep(input bit ee, input bit frc, input bit rdy);
        bit adv;
        bit accepted;
        if (!ee) return;
        adv = 1'b0;
        accepted = 1'b0;
        if (m_pending) begin
            if (rdy) begin
                m_shadow[m_adr] = m_dat;
                m_pending = 1'b0;
                accepted = 1'b1;
                adv = 1'b1;
                if (m_force_left > 0) m_force_left--;
            end
        end else if (img[m_ptr] != m_shadow[m_ptr] || m_force_left > 0 || frc) begin
            m_pending = 1'b1;
            m_adr = m_ptr;
            m_dat = img[m_ptr];
        end else begin
            adv = 1'b1;
        end
        if (frc) m_force_left = accepted ? N - 1 : N;
        m_wrap = adv && (m_ptr == N - 1);
        if (adv) m_ptr = (m_ptr + 1) % N;
    endtask

    task automatic applyStimulus(input bit ee, input bit frc, input bit rdy);
        CK_EE = ee;
        FORCE = frc;
        RDY = rdy;
        modelStep(ee, frc, rdy);
        @(negedge CK);
        compareAll();
    endtask

    task automatic doReset();
        #2 XARST = 1'b0;
        #1;
        modelReset();
        checkOutput("async_vld", 32'(vld), 32'd0);
        compareAll();
        @(negedge CK);
        XARST = 1'b1;
    endtask

    initial begin
        int nWrap;
        int nVld;
        int nUpd;
        int firstAdr;
        int lastAdr;
        int lastDat;
        bit prevVld;
        bit found;

        for (int k = 0; k < N; k++) img[k] = 8'h00;
        modelReset();
        @(negedge CK);
        checkOutput("reset_vld", 32'(vld), 32'd0);
        compareAll();
        XARST = 1'b1;

        // Quiet image: no updates, a wrap every N enabled cycles
        nWrap = 0;
        nVld = 0;
        repeat (260) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            if (wrap) nWrap++;
            if (vld) nVld++;
        end
        checkOutput("s1_wraps", 32'(nWrap), 32'd2);
        checkOutput("s1_novld", 32'(nVld), 32'd0);

        // Single change reported exactly once
        img[5] = 8'hA5;
        nUpd = 0;
        lastAdr = 0;
        lastDat = 0;
        repeat (3 * N) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            if (vld) begin
                nUpd++;
                lastAdr = int'(adr);
                lastDat = int'(dat);
            end
        end
        checkOutput("s2_count", 32'(nUpd), 32'd1);
        checkOutput("s2_adr", 32'(lastAdr), 32'd5);
        checkOutput("s2_dat", 32'(lastDat), 32'hA5);

        // Back-pressure keeps the update stable
        img[9] = 8'h3C;
        for (int i = 0; i < 300 && !vld; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_vld", 32'(vld), 32'd1);
        repeat (20) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("s3_hold_vld", 32'(vld), 32'd1);
            checkOutput("s3_hold_adr", 32'(adr), 32'd9);
            checkOutput("s3_hold_dat", 32'(dat), 32'h3C);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("s3_accepted", 32'(vld), 32'd0);

        // Full force lap starting at pointer 40
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_ptr == 40 && !m_pending) begin
                found = 1'b1;
                break;
            end
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkOutput("s4_reach_ptr", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        nUpd = 0;
        firstAdr = -1;
        lastAdr = -1;
        for (int i = 0; i < 300; i++) begin
            if (vld) begin
                if (nUpd == 0) firstAdr = int'(adr);
                lastAdr = int'(adr);
                nUpd++;
            end
            applyStimulus(1'b1, 1'b0, 1'b1);
        end
        checkOutput("s4_count", 32'(nUpd), 32'd128);
        checkOutput("s4_first", 32'(firstAdr), 32'd40);
        checkOutput("s4_last", 32'(lastAdr), 32'd39);
        checkOutput("s4_bsy_done", 32'(bsy), 32'd0);

        // Sparse enable: same single update, just slower
        img[12] = 8'h5A;
        nUpd = 0;
        lastAdr = 0;
        lastDat = 0;
        prevVld = vld;
        for (int i = 0; i < 12 * N; i++) begin
            applyStimulus(i % 4 == 0, 1'b0, 1'b1);
            if (vld && !prevVld) begin
                nUpd++;
                lastAdr = int'(adr);
                lastDat = int'(dat);
            end
            prevVld = vld;
        end
        checkOutput("s5_count", 32'(nUpd), 32'd1);
        checkOutput("s5_adr", 32'(lastAdr), 32'd12);
        checkOutput("s5_dat", 32'(lastDat), 32'h5A);

        // Reset while an update is held; the byte is reported again afterwards
        img[7] = 8'h11;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (vld && adr == 7'd7) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("s6_held", 32'(found), 32'd1);
        doReset();
        found = 1'b0;
        lastDat = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            if (vld && adr == 7'd7) begin
                found = 1'b1;
                lastDat = int'(dat);
                break;
            end
        end
        checkOutput("s6_rereport", 32'(found), 32'd1);
        checkOutput("s6_dat", 32'(lastDat), 32'h11);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) img[$urandom_range(0, N - 1)] = 8'($urandom);
            if ($urandom_range(0, 499) == 0) doReset();
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                          1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
